fifo_rd_stream: RTL



---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_skid2.sv | 57 +++++
 rtl/fifo_rd_stream.sv | 79 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side drain engine.
package fifo_pkg;

  localparam int unsigned DSIZE_DEF = 8;

  typedef enum logic {
    IDLE,
    PKT
  } state_e;

  // Buffer entry at the default data width.
  typedef struct packed {
    logic [DSIZE_DEF-1:0] data;
    logic                 last;
  } entry_t;

  // Width of a counter that holds 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry output buffer: simultaneous push and pop are both honoured.
module fifo_skid2 #(
  parameter int unsigned W = 9
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         do_pop;

  assign do_pop = pop_i & (cnt_q != 2'd0);

  // Occupancy next state: push-only grows, pop-only shrinks, both cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !do_pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push_i && do_pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign head_o = mem_q[rptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: fetches from the FIFO read port, absorbs the
// registered read latency and presents packets on a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned BURST = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             drain_en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy
);

  localparam int unsigned    IW       = idx_w(BURST);
  localparam logic [IW-1:0]  LAST_IDX = IW'(BURST - 1);

  state_e          state_q;
  logic [IW-1:0]   fetch_idx_q;
  logic            infl_q;
  logic            tag_q;

  logic [1:0]      cnt;
  logic [DSIZE:0]  head;
  logic            pop;
  logic            fetch_last;
  logic            credit_ok;

  assign pop        = m_valid & m_ready;
  assign fetch_last = (fetch_idx_q == LAST_IDX);

  // cnt + infl - pop < 2, rearranged so the arithmetic stays unsigned.
  assign credit_ok = (({1'b0, cnt} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop}));

  assign rinc = rrst_n & ~rempty & ((state_q == PKT) | drain_en) & credit_ok;

  // Packet FSM, beat counter and in-flight read tracking.
  // With BURST=1 every fetch is last, so the machine never leaves IDLE.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= IDLE;
      fetch_idx_q <= '0;
      infl_q      <= 1'b0;
      tag_q       <= 1'b0;
    end else begin
      infl_q <= rinc;
      if (rinc) begin
        tag_q       <= fetch_last;
        fetch_idx_q <= fetch_last ? '0 : fetch_idx_q + 1'b1;
        state_q     <= fetch_last ? IDLE : PKT;
      end
    end
  end

  fifo_skid2 #(
    .W (DSIZE + 1)
  ) u_buf (
    .clk_i  (rclk),
    .rst_ni (rrst_n),
    .push_i (infl_q),
    .data_i ({rdata, tag_q}),
    .pop_i  (pop),
    .head_o (head),
    .cnt_o  (cnt)
  );

  assign m_data  = head[DSIZE:1];
  assign m_last  = head[0];
  assign m_valid = (cnt != 2'd0);
  assign busy    = (state_q == PKT) | infl_q | (cnt != 2'd0);

endmodule
